// File: rtl/neuron_mac_ctrl_if.sv
// Operand-fetch, multiplier and result-handshake signals shared by the MAC controller
// and its environment (RAMs, multiplier, activation stage).
interface neuron_mac_ctrl_if #(
    parameter int unsigned BIT    = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ACC_W  = 24
);
    logic              start;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [BIT-1:0]    weight;
    logic [BIT-1:0]    pixel;
    logic [BIT-1:0]    mul_a;
    logic [BIT-1:0]    mul_b;
    logic [2*BIT-2:0]  mul_p;
    logic [ACC_W-1:0]  acc;
    logic              valid;
    logic              ready;

    modport master (
        input  start, weight, pixel, mul_p, ready,
        output busy, rd_en, addr, mul_a, mul_b, acc, valid
    );

    modport slave (
        output start, weight, pixel, mul_p, ready,
        input  busy, rd_en, addr, mul_a, mul_b, acc, valid
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Dot-product sequencer for one neuron: fetch, multiply (sign-magnitude), accumulate (two's
// complement), hand off over valid/ready. Define MAC_SAT_EN for a saturating add and ovf flag.
module neuron_mac_ctrl #(
    parameter int unsigned BIT    = 8,
    parameter int unsigned LEN    = 784,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ACC_W  = 24
) (
    input logic               clk,
    input logic               rst_n,
    neuron_mac_ctrl_if.master bus
`ifdef MAC_SAT_EN
    ,
    output logic              ovf
`endif
);
    localparam int unsigned       PW      = 2 * BIT - 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LEN - 1);

    typedef enum logic [2:0] {StIdle, StRead, StLoad, StAccum, StDone} state_e;

    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic [ACC_W-1:0]  mag;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  sum;
`ifdef MAC_SAT_EN
    logic [ACC_W:0]    wide;
    logic              clamp;
`endif

    // Negative zero negates to zero, so no special case is needed.
    always_comb begin
        mag  = ACC_W'(bus.mul_p[PW-2:0]);
        term = bus.mul_p[PW-1] ? -mag : mag;
`ifdef MAC_SAT_EN
        wide  = {bus.acc[ACC_W-1], bus.acc} + {term[ACC_W-1], term};
        clamp = wide[ACC_W] ^ wide[ACC_W-1];
        sum   = clamp ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
        sum   = bus.acc + term;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            idx       <= '0;
            bus.acc   <= '0;
            bus.addr  <= '0;
            bus.mul_a <= '0;
            bus.mul_b <= '0;
            bus.rd_en <= 1'b0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
`ifdef MAC_SAT_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        idx       <= '0;
                        bus.acc   <= '0;
                        bus.addr  <= '0;
                        bus.rd_en <= 1'b1;
                        bus.busy  <= 1'b1;
`ifdef MAC_SAT_EN
                        ovf       <= 1'b0;
`endif
                        state     <= StRead;
                    end
                end
                StRead: begin
                    bus.rd_en <= 1'b0;
                    state     <= StLoad;
                end
                StLoad: begin
                    bus.mul_a <= bus.weight;
                    bus.mul_b <= bus.pixel;
                    state     <= StAccum;
                end
                StAccum: begin
                    bus.acc <= sum;
`ifdef MAC_SAT_EN
                    ovf     <= ovf | clamp;
`endif
                    if (idx == LastIdx) begin
                        state <= StDone;
                    end else begin
                        idx       <= idx + 1'b1;
                        bus.addr  <= idx + 1'b1;
                        bus.rd_en <= 1'b1;
                        state     <= StRead;
                    end
                end
                StDone: begin
                    // valid rises one cycle into DONE; ready only counts once it is visible.
                    if (!bus.valid) begin
                        bus.valid <= 1'b1;
                    end else if (bus.ready) begin
                        bus.valid <= 1'b0;
                        bus.busy  <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Bench for neuron_mac_ctrl: three instances (LEN=3/ACC_W=24, LEN=4/ACC_W=16, LEN=1/ACC_W=24),
// each with a RAM model and a sign-magnitude multiplier model.
module tb_neuron_mac_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]        wmem [3][4];
    logic [7:0]        pmem [3][4];
    logic [2:0]        start_v;
    logic [2:0]        ready_v;
    logic [2:0]        valid_o;
    logic [2:0]        busy_o;
    logic [2:0]        rd_o;
    logic [2:0][9:0]   addr_o;
    logic [2:0][23:0]  acc_o;
    logic [2:0][7:0]   mula_o;
    logic [2:0][7:0]   mulb_o;
`ifdef MAC_SAT_EN
    logic [2:0]        ovf_o;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned L  = (g == 0) ? 3 : (g == 1) ? 4 : 1;
        localparam int unsigned AW = (g == 1) ? 16 : 24;

        neuron_mac_ctrl_if #(.BIT(8), .ADDR_W(10), .ACC_W(AW)) bus ();

        neuron_mac_ctrl #(.BIT(8), .LEN(L), .ADDR_W(10), .ACC_W(AW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
`ifdef MAC_SAT_EN
            ,
            .ovf   (ovf_o[g])
`endif
        );

        assign bus.start = start_v[g];
        assign bus.ready = ready_v[g];
        assign bus.mul_p = {bus.mul_a[7] ^ bus.mul_b[7],
                            14'(bus.mul_a[6:0]) * 14'(bus.mul_b[6:0])};

        always @(posedge clk) begin
            if (bus.rd_en) begin
                bus.weight <= wmem[g][bus.addr[1:0]];
                bus.pixel  <= pmem[g][bus.addr[1:0]];
            end
        end

        assign valid_o[g] = bus.valid;
        assign busy_o[g]  = bus.busy;
        assign rd_o[g]    = bus.rd_en;
        assign addr_o[g]  = bus.addr;
        assign acc_o[g]   = 24'(bus.acc);
        assign mula_o[g]  = bus.mul_a;
        assign mulb_o[g]  = bus.mul_b;
    end

    function automatic int len_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 4 : 1;
    endfunction

    function automatic int accw_of(input int i);
        return (i == 1) ? 16 : 24;
    endfunction

    function automatic longint smv(input logic [7:0] x);
        return x[7] ? -longint'(x[6:0]) : longint'(x[6:0]);
    endfunction

    // Reference dot product: signed integer sum of products, clamped per add or wrapped.
    task automatic ref_dot(input int i, output logic [23:0] r, output logic o);
        longint s, hi, lo;
        int     accw;
        accw = accw_of(i);
        hi = (longint'(1) <<< (accw - 1)) - 1;
        lo = -(longint'(1) <<< (accw - 1));
        s  = 0;
        o  = 1'b0;
        for (int k = 0; k < len_of(i); k++) begin
            s += smv(wmem[i][k]) * smv(pmem[i][k]);
`ifdef MAC_SAT_EN
            if (s > hi) begin
                s = hi; o = 1'b1;
            end else if (s < lo) begin
                s = lo; o = 1'b1;
            end
`endif
        end
        r = 24'(s & ((longint'(1) <<< accw) - 1));
    endtask

    task automatic fill_random(input int i);
        for (int k = 0; k < 4; k++) begin
            wmem[i][k] = 8'($urandom);
            pmem[i][k] = 8'($urandom);
        end
    endtask

    task automatic run(input int i, output logic [23:0] acc, output int lat,
                       output logic [9:0] a0);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        a0  = addr_o[i];
        lat = 0;
        while (!valid_o[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_o[i]) begin
            checks++; failures++;
            $display("FAIL run_timeout inst=%0d no valid within 200 cycles", i);
        end
        acc = acc_o[i];
    endtask

    task automatic check_zero(input int i, input string name);
        logic [66:0] obs;
        obs = {busy_o[i], rd_o[i], addr_o[i], acc_o[i], mula_o[i], mulb_o[i], valid_o[i]};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL %s inst=%0d outputs=%h required 0", name, i, obs);
        end
`ifdef MAC_SAT_EN
        checks++;
        if (ovf_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL %s_ovf inst=%0d got %b required 0", name, i, ovf_o[i]);
        end
`endif
    endtask

    task automatic test_reset();
        #12;
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int          first = -1;
        int          cnt   = 0;
        logic [23:0] accv  = '0;
        wmem[0][0] = 8'h03; wmem[0][1] = 8'h85; wmem[0][2] = 8'h02;
        pmem[0][0] = 8'h04; pmem[0][1] = 8'h02; pmem[0][2] = 8'h01;
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            if (valid_o[0]) begin
                cnt++;
                if (first < 0) begin
                    first = e;
                    accv  = acc_o[0];
                end
            end
        end
        checks += 4;
        if (first !== 10) begin
            failures++; $display("FAIL basic_latency got edge %0d required 10", first);
        end
        if (cnt !== 1) begin
            failures++; $display("FAIL basic_valid_width got %0d cycles required 1", cnt);
        end
        if (accv !== 24'h000004) begin
            failures++; $display("FAIL basic_acc got %h required 000004", accv);
        end
        if (busy_o[0] !== 1'b0) begin
            failures++; $display("FAIL basic_idle_busy got %b required 0", busy_o[0]);
        end
    endtask

    task automatic test_addr_trace();
        logic exp_rd;
        fill_random(1);
        ready_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
            exp_rd = (e % 3 == 0) && (e / 3 < 4);
            checks++;
            if (rd_o[1] !== exp_rd) begin
                failures++;
                $display("FAIL addr_trace_rd edge=%0d got %b required %b", e, rd_o[1], exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (addr_o[1] !== 10'(e / 3)) begin
                    failures++;
                    $display("FAIL addr_trace_addr edge=%0d got %0d required %0d",
                             e, addr_o[1], e / 3);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] acc;
        logic [9:0]  a0;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            wmem[1][k] = 8'h7F;
            pmem[1][k] = 8'h7F;
        end
        run(1, acc, lat, a0);
        checks++;
`ifdef MAC_SAT_EN
        if (acc !== 24'h007FFF) begin
            failures++; $display("FAIL sat_acc got %h required 007fff", acc);
        end
        checks++;
        if (ovf_o[1] !== 1'b1) begin
            failures++; $display("FAIL sat_ovf got %b required 1", ovf_o[1]);
        end
`else
        if (acc !== 24'h00FC04) begin
            failures++; $display("FAIL wrap_acc got %h required 00fc04", acc);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [23:0] acc, exp_acc;
        logic [9:0]  a0;
        logic        exp_o;
        int          lat;
        fill_random(0);
        ref_dot(0, exp_acc, exp_o);
        ready_v[0] = 1'b0;
        run(0, acc, lat, a0);
        for (int c = 0; c < 5; c++) begin
            start_v[0] = (c == 2);
            @(negedge clk);
            checks += 3;
            if (valid_o[0] !== 1'b1) begin
                failures++; $display("FAIL bp_valid cycle=%0d got %b required 1", c, valid_o[0]);
            end
            if (acc_o[0] !== exp_acc) begin
                failures++;
                $display("FAIL bp_acc cycle=%0d got %h required %h", c, acc_o[0], exp_acc);
            end
            if (busy_o[0] !== 1'b1) begin
                failures++; $display("FAIL bp_busy cycle=%0d got %b required 1", c, busy_o[0]);
            end
        end
        // Start together with ready: only ready may act.
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        checks += 2;
        if (valid_o[0] !== 1'b0) begin
            failures++; $display("FAIL bp_release_valid got %b required 0", valid_o[0]);
        end
        if (busy_o[0] !== 1'b0) begin
            failures++; $display("FAIL bp_release_busy got %b required 0", busy_o[0]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rd_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_no_restart cycle=%0d rd=%b busy=%b required 0 0",
                         c, rd_o[0], busy_o[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] acc, exp_acc;
        logic [9:0]  a0;
        logic        exp_o;
        int          lat;
        fill_random(0);
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (addr_o[0] !== 10'd2 || busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre addr=%0d busy=%b required 2 1", addr_o[0], busy_o[0]);
        end
        rst_n = 1'b0;
        #1;
        check_zero(0, "midrst");
        #2;
        rst_n = 1'b1;
        fill_random(0);
        ref_dot(0, exp_acc, exp_o);
        run(0, acc, lat, a0);
        checks += 2;
        if (a0 !== 10'd0) begin
            failures++; $display("FAIL midrst_addr0 got %0d required 0", a0);
        end
        if (acc !== exp_acc) begin
            failures++; $display("FAIL midrst_acc got %h required %h", acc, exp_acc);
        end
    endtask

    task automatic test_len1();
        logic [23:0] acc;
        logic [9:0]  a0;
        int          lat;
        wmem[2][0] = 8'h81;
        pmem[2][0] = 8'h05;
        ready_v[2] = 1'b1;
        run(2, acc, lat, a0);
        checks += 2;
        if (acc !== 24'hFFFFFB) begin
            failures++; $display("FAIL len1_acc got %h required fffffb", acc);
        end
        if (lat !== 4) begin
            failures++; $display("FAIL len1_latency got %0d required 4", lat);
        end
    endtask

    task automatic test_random();
        logic [23:0] acc, exp_acc;
        logic [9:0]  a0;
        logic        exp_o;
        int          lat, i;
        for (int t = 0; t < 16; t++) begin
            i = t % 2;
            fill_random(i);
            ref_dot(i, exp_acc, exp_o);
            ready_v[i] = 1'b1;
            run(i, acc, lat, a0);
            checks += 2;
            if (acc !== exp_acc) begin
                failures++;
                $display("FAIL rand_acc run=%0d inst=%0d got %h required %h", t, i, acc, exp_acc);
            end
            if (lat !== 3 * len_of(i) + 1) begin
                failures++;
                $display("FAIL rand_latency run=%0d got %0d required %0d",
                         t, lat, 3 * len_of(i) + 1);
            end
`ifdef MAC_SAT_EN
            checks++;
            if (ovf_o[i] !== exp_o) begin
                failures++;
                $display("FAIL rand_ovf run=%0d got %b required %b", t, ovf_o[i], exp_o);
            end
`endif
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        ready_v = '0;
        test_reset();
        test_basic();
        test_addr_trace();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_len1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
